// File: rtl/simple_bist_driver.sv
// simple_bist_driver: LFSR stimulus generator and MISR response compactor for the
// `simple` timing benchmark. Drives inp1/inp2 and folds dut_out into a signature.
// Optional feature: define GOLDEN_CHECK_EN to build the golden-signature comparator
// that drives `pass`; without it `pass` is tied low.
module simple_bist_driver #(
    parameter int unsigned       LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter int unsigned       PATTERNS   = 256,
    parameter int unsigned       DUT_LAT    = 1,
    parameter int unsigned       MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_TAPS  = 16'hB400,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic                              tau2015_clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              inp1,
    output logic                              inp2,
    input  logic                              dut_out,
    output logic                              busy,
    output logic                              done,
    output logic [MISR_W-1:0]                 signature,
    output logic [$clog2(PATTERNS+1)-1:0]     pat_count,
    output logic                              pass
);

    localparam int unsigned CW = $clog2(PATTERNS + 1);
    localparam int unsigned DW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;   // pattern currently on inp1/inp2
    logic                inp1_q, inp1_d;
    logic                inp2_q, inp2_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [DUT_LAT-1:0]  cap_q, cap_d;     // delayed "pattern driven" flag
    logic [MISR_W-1:0]   sig_q, sig_d;
    logic                launch, last_pat, drain_end, capture;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s, input logic b);
        return ((s >> 1) ^ (s[0] ? MISR_TAPS : '0)) ^ (MISR_W'(b) << (MISR_W - 1));
    endfunction

    assign launch    = start && (state_q == StIdle || state_q == StDone);
    assign last_pat  = (cnt_q == CW'(PATTERNS));
    assign drain_end = (drain_q == DW'(DUT_LAT - 1));
    assign capture   = cap_q[DUT_LAT-1];

    // State register
    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start)     state_d = StRun;
            StRun:          if (last_pat)  state_d = StDrain;
            StDrain:        if (drain_end) state_d = StDone;
            default:                       state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == StRun) || (state_q == StDrain);
        done = (state_q == StDone);
    end

    // Datapath next state: pattern generation, counters, capture pipe and MISR
    always_comb begin
        lfsr_d  = lfsr_q;
        inp1_d  = 1'b0;
        inp2_d  = 1'b0;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        sig_d   = sig_q;
        cap_d   = DUT_LAT'({cap_q, state_q == StRun});
        if (capture) begin
            sig_d = misr_step(sig_q, dut_out);
        end
        if (launch) begin
            // Pattern 1 is registered on the start edge so it appears the next cycle
            lfsr_d = SEED;
            inp1_d = SEED[0];
            inp2_d = SEED[1];
            cnt_d  = CW'(1);
            sig_d  = '0;
        end else if (state_q == StRun) begin
            drain_d = '0;
            if (!last_pat) begin
                lfsr_d = lfsr_step(lfsr_q);
                inp1_d = lfsr_d[0];
                inp2_d = lfsr_d[1];
                cnt_d  = cnt_q + CW'(1);
            end
        end else if (state_q == StDrain) begin
            drain_d = drain_q + DW'(1);
        end
    end

    // Datapath registers; reset aborts any run in progress
    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= SEED;
            inp1_q  <= 1'b0;
            inp2_q  <= 1'b0;
            cnt_q   <= '0;
            drain_q <= '0;
            cap_q   <= '0;
            sig_q   <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            inp1_q  <= inp1_d;
            inp2_q  <= inp2_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            cap_q   <= cap_d;
            sig_q   <= sig_d;
        end
    end

    assign inp1      = inp1_q;
    assign inp2      = inp2_q;
    assign signature = sig_q;
    assign pat_count = cnt_q;

`ifdef GOLDEN_CHECK_EN
    logic pass_q;

    // Compare the final signature (including the last capture) on entry to DONE
    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else if (launch) begin
            pass_q <= 1'b0;
        end else if (state_q == StDrain && drain_end) begin
            pass_q <= (sig_d == GOLDEN_SIG);
        end
    end

    assign pass = pass_q;
`else
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_simple_bist_driver.sv
// Bench for simple_bist_driver: three instances (defaults, PATTERNS=1, DUT_LAT=3)
// against a behavioural model of the stimulus sequence and signature.
module tb_simple_bist_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start_p1, start_l3;
    logic [3:0] tt, tt3;

    // Main instance (defaults)
    logic inp1, inp2, dut_out, busy, done, pass;
    logic [15:0] signature;
    logic [8:0] pat_count;

    simple_bist_driver dut (
        .tau2015_clk(clk), .rst_n(rst_n), .start(start), .inp1(inp1), .inp2(inp2),
        .dut_out(dut_out), .busy(busy), .done(done), .signature(signature),
        .pat_count(pat_count), .pass(pass)
    );

    // Stand-in benchmark netlist: one flop holding a random function of inp1/inp2
    logic bm_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bm_q <= 1'b0;
        else        bm_q <= tt[{inp2, inp1}];
    end
    assign dut_out = bm_q;

    // PATTERNS=1 instance with response tied high
    logic p1_inp1, p1_inp2, p1_busy, p1_done, p1_pass;
    logic [15:0] p1_sig;
    logic [0:0] p1_cnt;

    simple_bist_driver #(.PATTERNS(1)) dut_p1 (
        .tau2015_clk(clk), .rst_n(rst_n), .start(start_p1), .inp1(p1_inp1), .inp2(p1_inp2),
        .dut_out(1'b1), .busy(p1_busy), .done(p1_done), .signature(p1_sig),
        .pat_count(p1_cnt), .pass(p1_pass)
    );

    // DUT_LAT=3 instance with a three-stage response pipeline
    logic l3_inp1, l3_inp2, l3_busy, l3_done, l3_pass, l3_out;
    logic [15:0] l3_sig;
    logic [3:0] l3_cnt;
    logic [2:0] l3_pipe;

    simple_bist_driver #(.PATTERNS(12), .DUT_LAT(3)) dut_l3 (
        .tau2015_clk(clk), .rst_n(rst_n), .start(start_l3), .inp1(l3_inp1), .inp2(l3_inp2),
        .dut_out(l3_out), .busy(l3_busy), .done(l3_done), .signature(l3_sig),
        .pat_count(l3_cnt), .pass(l3_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) l3_pipe <= '0;
        else        l3_pipe <= {l3_pipe[1:0], tt3[{l3_inp2, l3_inp1}]};
    end
    assign l3_out = l3_pipe[2];

    // Reference model
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] pats [0:255];

    typedef struct {
        logic [15:0] sig;
        int          cnt;
        logic        pass;
    } exp_t;
    exp_t sb[$];

    function automatic logic [15:0] model_sig(input int n, input logic [3:0] t);
        logic [15:0] m = 16'h0000;
        logic [3:0]  tv = t;
        logic        r;
        for (int k = 0; k < n; k++) begin
            r = tv[{pats[k][1], pats[k][0]}];
            m = ((m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000)) ^ {r, 15'b0};
        end
        return m;
    endfunction

    function automatic logic exp_pass(input logic [15:0] s);
`ifdef GOLDEN_CHECK_EN
        return s == 16'h0000;
`else
        return 1'b0 & s[0];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare on every rising edge of done
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("signature", 32'(signature), 32'(e.sig));
                check("pat_count", 32'(pat_count), 32'(e.cnt));
                check("pass", 32'(pass), 32'(e.pass));
            end
        end
        done_prev = done;
    end

    // Drive one run on the main instance; abort_at >= 0 resets mid-run
    task automatic run_main(input logic [3:0] t, input bit repulse, input int abort_at);
        exp_t e;
        int bc;
        logic [1:0] first5 [0:4];
        first5 = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        tt = t;
        if (abort_at < 0) begin
            e.sig  = model_sig(256, t);
            e.cnt  = 256;
            e.pass = exp_pass(e.sig);
            sb.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        for (int k = 0; k < 256; k++) begin
            check("inp pair", 32'({inp2, inp1}), 32'((k < 5) ? first5[k] : pats[k][1:0]));
            if (busy) bc++;
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("abort busy", 32'(busy), 32'd0);
                check("abort done", 32'(done), 32'd0);
                check("abort inp", 32'({inp2, inp1}), 32'd0);
                check("abort signature", 32'(signature), 32'd0);
                check("abort pat_count", 32'(pat_count), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            start = repulse && (k == 50);
            @(negedge clk);
        end
        start = 1'b0;
        for (int g = 0; g < 40 && busy; g++) begin
            bc++;
            @(negedge clk);
        end
        check("busy cycles", 32'(bc), 32'd257);
        check("done after run", 32'(done), 32'd1);
    endtask

    initial begin
        int bc;
        logic [3:0] t_a;
        pats[0] = 16'hACE1;
        for (int k = 1; k < 256; k++)
            pats[k] = (pats[k-1] >> 1) ^ (pats[k-1][0] ? 16'hB400 : 16'h0000);

        rst_n = 1'b0; start = 1'b0; start_p1 = 1'b0; start_l3 = 1'b0;
        tt = 4'h0; tt3 = 4'h0;
        #3;
        check("reset inp1", 32'(inp1), 32'd0);
        check("reset inp2", 32'(inp2), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pass", 32'(pass), 32'd0);
        check("reset signature", 32'(signature), 32'd0);
        check("reset pat_count", 32'(pat_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random response function, then check that DONE holds its results
        t_a = 4'($urandom_range(1, 14));
        run_main(t_a, 1'b0, -1);
        repeat (5) @(negedge clk);
        check("hold done", 32'(done), 32'd1);
        check("hold busy", 32'(busy), 32'd0);
        check("hold signature", 32'(signature), 32'(model_sig(256, t_a)));
        check("hold pat_count", 32'(pat_count), 32'd256);
        check("hold inp", 32'({inp2, inp1}), 32'd0);

        // Zero response
        run_main(4'h0, 1'b0, -1);
        // Same response function with start re-pulsed during RUN
        run_main(t_a, 1'b1, -1);
        // Abort at pattern 100, then a clean run
        run_main(4'($urandom), 1'b0, 99);
        check("after abort done", 32'(done), 32'd0);
        run_main(4'($urandom), 1'b0, -1);
        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Single-pattern instance
        start_p1 = 1'b1;
        @(negedge clk);
        start_p1 = 1'b0;
        bc = 0;
        for (int g = 0; g < 20 && p1_busy; g++) begin
            bc++;
            @(negedge clk);
        end
        check("p1 busy cycles", 32'(bc), 32'd2);
        check("p1 done", 32'(p1_done), 32'd1);
        check("p1 signature", 32'(p1_sig), 32'h8000);
        check("p1 pat_count", 32'(p1_cnt), 32'd1);
        check("p1 pass", 32'(p1_pass), 32'(exp_pass(16'h8000)));

        // Three-cycle latency instance
        tt3 = 4'($urandom);
        start_l3 = 1'b1;
        @(negedge clk);
        start_l3 = 1'b0;
        bc = 0;
        for (int k = 0; k < 12; k++) begin
            check("l3 inp pair", 32'({l3_inp2, l3_inp1}), 32'(pats[k][1:0]));
            if (l3_busy) bc++;
            @(negedge clk);
        end
        for (int g = 0; g < 20 && l3_busy; g++) begin
            bc++;
            @(negedge clk);
        end
        check("l3 busy cycles", 32'(bc), 32'd15);
        check("l3 done", 32'(l3_done), 32'd1);
        check("l3 signature", 32'(l3_sig), 32'(model_sig(12, tt3)));
        check("l3 pat_count", 32'(l3_cnt), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
